// File: rtl/sfp_ctrl_pkg.sv
// Shared types and encodings for the special-function stage sequencer.
package sfp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RD   = 3'd2,
        ST_LAT  = 3'd3,
        ST_ACC  = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } sfp_state_e;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    // psum SRAM strobes are active low
    localparam logic CEN_ON = 1'b0;
    localparam logic WEN_WR = 1'b0;

endpackage

// File: rtl/sfp_acc_ctrl_if.sv
// Bus between the sequencer (ctrl) and its environment: core controller, output FIFO,
// special-function stage and psum SRAM.
interface sfp_acc_ctrl_if
    import sfp_ctrl_pkg::*;
#(
    parameter int AW = 4,
    parameter int KW = 4
);
    logic          start;
    logic          mode_cfg;
    logic          relu_cfg;
    // FIFO is first-word-fall-through: while ofifo_valid=1 the head word is on the data bus,
    // and ofifo_rd=1 in a cycle both consumes that word and pops it; ofifo_rd is only raised
    // after ofifo_valid=1 was seen, and this block is the FIFO's only reader.
    logic          ofifo_valid;
    logic          ofifo_rd;
    logic          pmem_cen;
    logic          pmem_wen;
    logic [AW-1:0] pmem_addr;
    logic          sfp_acc;
    logic          sfp_relu_en;
    logic          sfp_mode;
    logic          busy;
    logic          done;
    logic [KW-1:0] kij_idx;
    sfp_state_e    state_dbg;

    modport ctrl (
        input  start, mode_cfg, relu_cfg, ofifo_valid,
        output ofifo_rd, pmem_cen, pmem_wen, pmem_addr, sfp_acc, sfp_relu_en, sfp_mode,
               busy, done, kij_idx, state_dbg
    );

    modport env (
        output start, mode_cfg, relu_cfg, ofifo_valid,
        input  ofifo_rd, pmem_cen, pmem_wen, pmem_addr, sfp_acc, sfp_relu_en, sfp_mode,
               busy, done, kij_idx, state_dbg
    );

endinterface

// File: rtl/sfp_idx_cnt.sv
// Nested position/kernel-iteration counter: out_idx is the inner loop, kij_idx the outer.
module sfp_idx_cnt #(
    parameter int NUM_OUT = 16,
    parameter int NUM_KIJ = 9,
    parameter int AW      = 4,
    parameter int KW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          step_i,
    input  logic          os_mode_i,
    output logic [AW-1:0] out_idx_o,
    output logic [KW-1:0] kij_idx_o,
    output logic          last_out_o,
    output logic          last_pass_o
);
    localparam logic [AW-1:0] OUT_LAST = AW'(NUM_OUT - 1);
    localparam logic [KW-1:0] KIJ_LAST = KW'(NUM_KIJ - 1);

    logic [AW-1:0] out_q, out_d;
    logic [KW-1:0] kij_q, kij_d;

    assign last_out_o  = (out_q == OUT_LAST);
    assign last_pass_o = os_mode_i || (kij_q == KIJ_LAST);
    assign out_idx_o   = out_q;
    assign kij_idx_o   = kij_q;

    // kij_idx saturates on the last pass so it can be read back after the job
    always_comb begin
        out_d = out_q;
        kij_d = kij_q;
        if (clear_i) begin
            out_d = '0;
            kij_d = '0;
        end else if (step_i) begin
            if (!last_out_o) begin
                out_d = out_q + 1'b1;
            end else begin
                out_d = '0;
                if (!last_pass_o) kij_d = kij_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            kij_q <= '0;
        end else begin
            out_q <= out_d;
            kij_q <= kij_d;
        end
    end

endmodule

// File: rtl/sfp_acc_ctrl.sv
// Accumulate + ReLU sequencer: pops FIFO words, merges prior psums (WS) or bypasses (OS),
// and writes each result back to the psum SRAM. All outputs decode registered state only.
module sfp_acc_ctrl
    import sfp_ctrl_pkg::*;
#(
    parameter int NUM_OUT = 16,
    parameter int NUM_KIJ = 9,
    parameter int AW      = 4,
    parameter int KW      = 4
) (
    input logic         clk,
    input logic         reset,
    sfp_acc_ctrl_if.ctrl bus
);
    localparam logic [KW-1:0] KIJ_LAST = KW'(NUM_KIJ - 1);

    sfp_state_e    state_q, state_d;
    logic          mode_q, mode_d;
    logic          relu_q, relu_d;
    logic [AW-1:0] out_idx;
    logic [KW-1:0] kij_idx;
    logic          last_out, last_pass;
    logic          cnt_clear, cnt_step;

    assign cnt_clear = (state_q == ST_IDLE) && bus.start;
    assign cnt_step  = (state_q == ST_WR);

    sfp_idx_cnt #(
        .NUM_OUT(NUM_OUT),
        .NUM_KIJ(NUM_KIJ),
        .AW     (AW),
        .KW     (KW)
    ) u_idx_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .step_i     (cnt_step),
        .os_mode_i  (mode_q == MODE_OS),
        .out_idx_o  (out_idx),
        .kij_idx_o  (kij_idx),
        .last_out_o (last_out),
        .last_pass_o(last_pass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WS;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            relu_q  <= relu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        relu_d  = relu_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) begin
                mode_d  = bus.mode_cfg;
                relu_d  = bus.relu_cfg;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (bus.ofifo_valid) begin
                // first pass and OS have no prior psum to fetch
                state_d = ((mode_q == MODE_WS) && (kij_idx != '0)) ? ST_RD : ST_ACC;
            end
            ST_RD:   state_d = ST_LAT;
            ST_LAT:  state_d = ST_ACC;
            ST_ACC:  state_d = ST_WR;
            ST_WR:   state_d = (last_out && last_pass) ? ST_DONE : ST_WAIT;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ofifo_rd    = 1'b0;
        bus.pmem_cen    = ~CEN_ON;
        bus.pmem_wen    = ~WEN_WR;
        bus.pmem_addr   = '0;
        bus.sfp_acc     = 1'b0;
        bus.sfp_relu_en = 1'b0;
        unique case (state_q)
            ST_RD: begin
                bus.pmem_cen  = CEN_ON;
                bus.pmem_addr = out_idx;
            end
            ST_ACC: begin
                bus.ofifo_rd    = 1'b1;
                bus.sfp_acc     = (mode_q == MODE_WS) && (kij_idx != '0);
                bus.sfp_relu_en = (mode_q == MODE_WS) && relu_q && (kij_idx == KIJ_LAST);
            end
            ST_WR: begin
                bus.pmem_cen  = CEN_ON;
                bus.pmem_wen  = WEN_WR;
                bus.pmem_addr = out_idx;
            end
            default: ;
        endcase
    end

    assign bus.sfp_mode  = mode_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.kij_idx   = kij_idx;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sfp_acc_ctrl.sv
// Directed bench for sfp_acc_ctrl with a psum SRAM + special-function stage model.
module tb_sfp_acc_ctrl;
    import sfp_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sfp_acc_ctrl_if #(.AW(4), .KW(4)) bus ();

    sfp_acc_ctrl #(.NUM_OUT(16), .NUM_KIJ(9), .AW(4), .KW(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.ctrl)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // environment model state
    int fifo_q[$];
    int mem[16];
    int wr_addr_q[$];
    int psum_latch, sram_dout, sfp_out;
    bit prev_rd;
    int t0, busy1, done_cyc, done_cnt;
    int pops, reads, writes, acc_cnt, relu_cnt, ctl_bad, rd_kij0, acc_kij0, underflow;
    bit stall_en, stall_watch;
    int stall_left, stall_viol, stall_rd_addr;

    initial begin
        int data, res;
        prev_rd = 0;
        stall_left = 0;
        bus.ofifo_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rd = 0;
            end else begin
                if (prev_rd) psum_latch = sram_dout;
                prev_rd = 0;
                if (stall_left > 0) begin
                    stall_left--;
                    if (!bus.pmem_cen) stall_viol++;
                    if (stall_left == 0) stall_watch = 1;
                end
                if (!bus.pmem_cen && bus.pmem_wen) begin
                    reads++;
                    if (writes < 16) rd_kij0++;
                    sram_dout = mem[bus.pmem_addr];
                    prev_rd = 1;
                    if (stall_watch) begin
                        stall_rd_addr = int'(bus.pmem_addr);
                        stall_watch = 0;
                    end
                end
                if (bus.ofifo_rd) begin
                    if (fifo_q.size() != 0) data = fifo_q.pop_front();
                    else begin data = 0; underflow++; end
                    if (pops < 16 && bus.sfp_acc) acc_kij0++;
                    res = (bus.sfp_acc ? psum_latch : 0) + data;
                    if (bus.sfp_relu_en && res < 0) res = 0;
                    sfp_out = res;
                    pops++;
                    if (bus.sfp_acc) acc_cnt++;
                    if (bus.sfp_relu_en) relu_cnt++;
                end else if (bus.sfp_acc || bus.sfp_relu_en) begin
                    ctl_bad++;
                end
                if (!bus.pmem_cen && !bus.pmem_wen) begin
                    mem[bus.pmem_addr] = sfp_out;
                    writes++;
                    wr_addr_q.push_back(int'(bus.pmem_addr));
                    // 11 = WR cycle plus ten WAIT cycles that see an empty FIFO
                    if (stall_en && writes == 53) stall_left = 11;
                end
                if (bus.done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc - t0;
                end
            end
            bus.ofifo_valid = (fifo_q.size() != 0) && (stall_left == 0);
        end
    end

    task automatic start_job(input bit mode, input bit relu, input bit stall);
        int nk;
        pops = 0; reads = 0; writes = 0; acc_cnt = 0; relu_cnt = 0; ctl_bad = 0;
        rd_kij0 = 0; acc_kij0 = 0; underflow = 0; done_cnt = 0; done_cyc = -1;
        stall_viol = 0; stall_rd_addr = -1; stall_watch = 0; stall_en = stall;
        psum_latch = 0; sfp_out = 0;
        wr_addr_q.delete();
        for (int a = 0; a < 16; a++) mem[a] = 0;
        nk = mode ? 1 : 9;
        for (int k = 0; k < nk; k++)
            for (int a = 0; a < 16; a++) fifo_q.push_back(k + a - 20);
        @(negedge clk);
        bus.mode_cfg = mode;
        bus.relu_cfg = relu;
        bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        busy1 = int'(bus.busy);
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin ok = 1; break; end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL done_timeout: got no done within %0d cycles, want done", budget); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.mode_cfg = 1'b0; bus.relu_cfg = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.ofifo_rd !== 1'b0) begin n_bad++; $display("FAIL rst_ofifo_rd: got %b want 0", bus.ofifo_rd); end
        n_cmp++; if (bus.pmem_cen !== 1'b1) begin n_bad++; $display("FAIL rst_pmem_cen: got %b want 1", bus.pmem_cen); end
        n_cmp++; if (bus.pmem_wen !== 1'b1) begin n_bad++; $display("FAIL rst_pmem_wen: got %b want 1", bus.pmem_wen); end
        n_cmp++; if (bus.pmem_addr !== 4'd0) begin n_bad++; $display("FAIL rst_pmem_addr: got %0d want 0", bus.pmem_addr); end
        n_cmp++; if (bus.sfp_acc !== 1'b0) begin n_bad++; $display("FAIL rst_sfp_acc: got %b want 0", bus.sfp_acc); end
        n_cmp++; if (bus.sfp_relu_en !== 1'b0) begin n_bad++; $display("FAIL rst_sfp_relu_en: got %b want 0", bus.sfp_relu_en); end
        n_cmp++; if (bus.sfp_mode !== 1'b0) begin n_bad++; $display("FAIL rst_sfp_mode: got %b want 0", bus.sfp_mode); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.kij_idx !== 4'd0) begin n_bad++; $display("FAIL rst_kij_idx: got %0d want 0", bus.kij_idx); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    // WS without ReLU: final psum[a] = sum_{k=0..8}(k+a-20) = 9a-144
    task automatic test_ws_accumulate();
        start_job(1'b0, 1'b0, 1'b0);
        n_cmp++; if (busy1 !== 1) begin n_bad++; $display("FAIL ws_busy_c1: got %0d want 1", busy1); end
        wait_done(1000);
        n_cmp++; if (done_cyc !== 689) begin n_bad++; $display("FAIL ws_done_cycle: got %0d want 689", done_cyc); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ws_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (pops !== 144) begin n_bad++; $display("FAIL ws_pops: got %0d want 144", pops); end
        n_cmp++; if (reads !== 128) begin n_bad++; $display("FAIL ws_reads: got %0d want 128", reads); end
        n_cmp++; if (writes !== 144) begin n_bad++; $display("FAIL ws_writes: got %0d want 144", writes); end
        n_cmp++; if (acc_cnt !== 128) begin n_bad++; $display("FAIL ws_acc_cycles: got %0d want 128", acc_cnt); end
        n_cmp++; if (relu_cnt !== 0) begin n_bad++; $display("FAIL ws_relu_off: got %0d want 0", relu_cnt); end
        n_cmp++; if (rd_kij0 !== 0) begin n_bad++; $display("FAIL ws_kij0_reads: got %0d want 0", rd_kij0); end
        n_cmp++; if (acc_kij0 !== 0) begin n_bad++; $display("FAIL ws_kij0_acc: got %0d want 0", acc_kij0); end
        n_cmp++; if (ctl_bad !== 0) begin n_bad++; $display("FAIL ws_ctl_outside_acc: got %0d want 0", ctl_bad); end
        n_cmp++; if (underflow !== 0) begin n_bad++; $display("FAIL ws_underflow: got %0d want 0", underflow); end
        n_cmp++; if (bus.kij_idx !== 4'd8) begin n_bad++; $display("FAIL ws_kij_final: got %0d want 8", bus.kij_idx); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ws_busy_after: got %b want 0", bus.busy); end
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (mem[a] !== 9 * a - 144) begin n_bad++; $display("FAIL ws_psum[%0d]: got %0d want %0d", a, mem[a], 9 * a - 144); end
        end
    endtask

    // WS with ReLU on the last pass: every sum is negative, so all results clamp to 0
    task automatic test_ws_relu();
        start_job(1'b0, 1'b1, 1'b0);
        wait_done(1000);
        n_cmp++; if (done_cyc !== 689) begin n_bad++; $display("FAIL relu_done_cycle: got %0d want 689", done_cyc); end
        n_cmp++; if (relu_cnt !== 16) begin n_bad++; $display("FAIL relu_cycles: got %0d want 16", relu_cnt); end
        n_cmp++; if (ctl_bad !== 0) begin n_bad++; $display("FAIL relu_ctl_outside_acc: got %0d want 0", ctl_bad); end
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (mem[a] !== 0) begin n_bad++; $display("FAIL relu_psum[%0d]: got %0d want 0", a, mem[a]); end
        end
    endtask

    task automatic test_os();
        start_job(1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus.sfp_mode !== 1'b1) begin n_bad++; $display("FAIL os_sfp_mode: got %b want 1", bus.sfp_mode); end
        wait_done(200);
        n_cmp++; if (done_cyc !== 49) begin n_bad++; $display("FAIL os_done_cycle: got %0d want 49", done_cyc); end
        n_cmp++; if (reads !== 0) begin n_bad++; $display("FAIL os_reads: got %0d want 0", reads); end
        n_cmp++; if (pops !== 16) begin n_bad++; $display("FAIL os_pops: got %0d want 16", pops); end
        n_cmp++; if (writes !== 16) begin n_bad++; $display("FAIL os_writes: got %0d want 16", writes); end
        n_cmp++; if (acc_cnt + relu_cnt !== 0) begin n_bad++; $display("FAIL os_acc_relu: got %0d want 0", acc_cnt + relu_cnt); end
        n_cmp++; if (bus.kij_idx !== 4'd0) begin n_bad++; $display("FAIL os_kij_final: got %0d want 0", bus.kij_idx); end
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (a >= wr_addr_q.size() || wr_addr_q[a] !== a) begin
                n_bad++; $display("FAIL os_wr_addr[%0d]: got %0d want %0d", a, (a < wr_addr_q.size()) ? wr_addr_q[a] : -1, a);
            end
            n_cmp++;
            if (mem[a] !== a - 20) begin n_bad++; $display("FAIL os_psum[%0d]: got %0d want %0d", a, mem[a], a - 20); end
        end
    endtask

    task automatic test_fifo_stall();
        start_job(1'b0, 1'b0, 1'b1);
        wait_done(1000);
        n_cmp++; if (done_cyc !== 699) begin n_bad++; $display("FAIL stall_done_cycle: got %0d want 699", done_cyc); end
        n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL stall_sram_access: got %0d want 0", stall_viol); end
        n_cmp++; if (stall_rd_addr !== 5) begin n_bad++; $display("FAIL stall_resume_addr: got %0d want 5", stall_rd_addr); end
        n_cmp++; if (pops !== 144) begin n_bad++; $display("FAIL stall_pops: got %0d want 144", pops); end
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (mem[a] !== 9 * a - 144) begin n_bad++; $display("FAIL stall_psum[%0d]: got %0d want %0d", a, mem[a], 9 * a - 144); end
        end
        stall_en = 0;
    endtask

    task automatic test_start_ignored_and_abort();
        bit seen;
        int wr_at_acc;
        start_job(1'b0, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pops >= 20) begin seen = 1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL abort_reach_kij1: got pops=%0d want >=20", pops); end
        bus.mode_cfg = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode_cfg = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ofifo_rd) begin seen = 1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL abort_acc_timeout: got no ACC, want ACC within 20 cycles"); end
        n_cmp++; if (bus.state_dbg !== ST_ACC) begin n_bad++; $display("FAIL abort_state_acc: got %0d want %0d", int'(bus.state_dbg), int'(ST_ACC)); end
        n_cmp++; if (bus.kij_idx !== 4'd1) begin n_bad++; $display("FAIL start_ignored_kij: got %0d want 1", bus.kij_idx); end
        n_cmp++; if (bus.sfp_acc !== 1'b1) begin n_bad++; $display("FAIL start_ignored_acc: got %b want 1", bus.sfp_acc); end
        n_cmp++; if (bus.sfp_mode !== 1'b0) begin n_bad++; $display("FAIL start_ignored_mode: got %b want 0", bus.sfp_mode); end
        wr_at_acc = writes;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL abort_state_idle: got %0d want %0d", int'(bus.state_dbg), int'(ST_IDLE)); end
        n_cmp++; if (bus.pmem_cen !== 1'b1) begin n_bad++; $display("FAIL abort_pmem_cen: got %b want 1", bus.pmem_cen); end
        n_cmp++; if (bus.kij_idx !== 4'd0) begin n_bad++; $display("FAIL abort_kij: got %0d want 0", bus.kij_idx); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        reset = 1'b0;
        fifo_q.delete();
        repeat (5) @(negedge clk);
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        n_cmp++; if (writes !== wr_at_acc) begin n_bad++; $display("FAIL abort_no_write: got %0d want %0d", writes, wr_at_acc); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got %b want 0", bus.busy); end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mode_cfg = 1'b0;
        bus.relu_cfg = 1'b0;
        stall_en = 0;
        test_reset();
        test_ws_accumulate();
        test_ws_relu();
        test_os();
        test_fifo_stall();
        test_start_ignored_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
